// File: rtl/div_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_issue_ctrl                                                  |
// | Purpose  : Execute-stage front end for RV32M DIV/DIVU/REM/REMU. Accepts one |
// |            request, starts the long-division divider, waits for it (with a |
// |            watchdog), selects quotient or remainder and returns a single   |
// |            one-cycle response. req_ready is low while an op is in flight.  |
// | Ports    : clk, nrst (async active-low)                                    |
// |            req_valid/req_ready/req_funct3/req_rs1/req_rs2 : request side   |
// |            flush                                 : kill in-flight op       |
// |            resp_valid/resp_data/resp_dbz/resp_ovf/resp_err : response side |
// |            div_en/div_a/div_b/div_is_signed      : divider command         |
// |            div_ready/div_q/div_r/div_by_zero/div_overflow : divider result |
// | Options  : DIV_RESULT_REUSE_EN - single-entry result cache; a repeated      |
// |            legal request with the same operands and signedness answers     |
// |            without starting the divider.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module div_issue_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 63
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            flush,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_dbz,
   output logic            resp_ovf,
   output logic            resp_err,
   output logic            div_en,
   output logic [XLEN-1:0] div_a,
   output logic [XLEN-1:0] div_b,
   output logic            div_is_signed,
   input  logic            div_ready,
   input  logic [XLEN-1:0] div_q,
   input  logic [XLEN-1:0] div_r,
   input  logic            div_by_zero,
   input  logic            div_overflow
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]      state_q, state_d;
   logic [1:0]      op_q, op_d;          // funct3[1:0]: [1]=remainder, [0]=unsigned
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic            drain_first_q, drain_first_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic            resp_dbz_q, resp_dbz_d;
   logic            resp_ovf_q, resp_ovf_d;
   logic            resp_err_q, resp_err_d;

`ifdef DIV_RESULT_REUSE_EN
   logic            cache_valid_q, cache_valid_d;
   logic [XLEN-1:0] cache_a_q, cache_a_d;
   logic [XLEN-1:0] cache_b_q, cache_b_d;
   logic            cache_signed_q, cache_signed_d;
   logic [XLEN-1:0] cache_quo_q, cache_quo_d;
   logic [XLEN-1:0] cache_rem_q, cache_rem_d;
   logic            cache_dbz_q, cache_dbz_d;
   logic            cache_ovf_q, cache_ovf_d;
   logic            cache_hit;

   assign cache_hit = cache_valid_q && (cache_a_q == req_rs1) && (cache_b_q == req_rs2) &&
                      (cache_signed_q == ~req_funct3[0]);
`endif

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      counter_d     = counter_q;
      drain_first_d = 1'b0;
      // Response registers are loaded only on the transition into RESP and
      // fall back to zero otherwise, giving the one-cycle pulse.
      resp_valid_d  = 1'b0;
      resp_data_d   = '0;
      resp_dbz_d    = 1'b0;
      resp_ovf_d    = 1'b0;
      resp_err_d    = 1'b0;
`ifdef DIV_RESULT_REUSE_EN
      cache_valid_d  = cache_valid_q;
      cache_a_d      = cache_a_q;
      cache_b_d      = cache_b_q;
      cache_signed_d = cache_signed_q;
      cache_quo_d    = cache_quo_q;
      cache_rem_d    = cache_rem_q;
      cache_dbz_d    = cache_dbz_q;
      cache_ovf_d    = cache_ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A flush in IDLE drops any concurrent request.
            if (req_valid && !flush) begin
               if (req_funct3[2]) begin
                  op_d    = req_funct3[1:0];
                  a_d     = req_rs1;
                  b_d     = req_rs2;
                  state_d = ST_ISSUE;
`ifdef DIV_RESULT_REUSE_EN
                  if (cache_hit) begin
                     state_d      = ST_RESP;
                     resp_valid_d = 1'b1;
                     resp_data_d  = req_funct3[1] ? cache_rem_q : cache_quo_q;
                     resp_dbz_d   = cache_dbz_q;
                     resp_ovf_d   = cache_ovf_q;
                  end
`endif
               end else begin
                  // Illegal encoding: answer with an error, divider untouched.
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            counter_d = '0;
            if (flush) begin
               state_d       = ST_DRAIN;
               drain_first_d = 1'b1;
`ifdef DIV_RESULT_REUSE_EN
               cache_valid_d = 1'b0;
`endif
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            counter_d = counter_q + CNT_W'(1);
            if (flush) begin
               state_d = ST_DRAIN;
`ifdef DIV_RESULT_REUSE_EN
               cache_valid_d = 1'b0;
`endif
            end else if (div_ready) begin
               // Completion takes priority over a coincident watchdog expiry.
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = op_q[1] ? div_r : div_q;
               resp_dbz_d   = div_by_zero;
               resp_ovf_d   = div_overflow;
`ifdef DIV_RESULT_REUSE_EN
               cache_valid_d  = 1'b1;
               cache_a_d      = a_q;
               cache_b_d      = b_q;
               cache_signed_d = ~op_q[0];
               cache_quo_d    = div_q;
               cache_rem_d    = div_r;
               cache_dbz_d    = div_by_zero;
               cache_ovf_d    = div_overflow;
`endif
            end else if (counter_q == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
`ifdef DIV_RESULT_REUSE_EN
               cache_valid_d = 1'b0;
`endif
            end
         end
         ST_DRAIN: begin
`ifdef DIV_RESULT_REUSE_EN
            if (flush) cache_valid_d = 1'b0;
`endif
            // Straight after ISSUE the divider may still show its idle ready,
            // so that first cycle's div_ready is not trusted.
            if (div_ready && !drain_first_q) state_d = ST_IDLE;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         counter_q     <= '0;
         drain_first_q <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         resp_dbz_q    <= 1'b0;
         resp_ovf_q    <= 1'b0;
         resp_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         a_q           <= a_d;
         b_q           <= b_d;
         counter_q     <= counter_d;
         drain_first_q <= drain_first_d;
         resp_valid_q  <= resp_valid_d;
         resp_data_q   <= resp_data_d;
         resp_dbz_q    <= resp_dbz_d;
         resp_ovf_q    <= resp_ovf_d;
         resp_err_q    <= resp_err_d;
      end
   end

`ifdef DIV_RESULT_REUSE_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cache_valid_q  <= 1'b0;
         cache_a_q      <= '0;
         cache_b_q      <= '0;
         cache_signed_q <= 1'b0;
         cache_quo_q    <= '0;
         cache_rem_q    <= '0;
         cache_dbz_q    <= 1'b0;
         cache_ovf_q    <= 1'b0;
      end else begin
         cache_valid_q  <= cache_valid_d;
         cache_a_q      <= cache_a_d;
         cache_b_q      <= cache_b_d;
         cache_signed_q <= cache_signed_d;
         cache_quo_q    <= cache_quo_d;
         cache_rem_q    <= cache_rem_d;
         cache_dbz_q    <= cache_dbz_d;
         cache_ovf_q    <= cache_ovf_d;
      end
   end
`endif

   assign req_ready     = (state_q == ST_IDLE);
   assign div_en        = (state_q == ST_ISSUE);
   assign div_a         = a_q;
   assign div_b         = b_q;
   assign div_is_signed = ~op_q[0];

   // A flush during RESP suppresses the pulse; flags never show without it.
   assign resp_valid = resp_valid_q && !flush;
   assign resp_data  = resp_data_q;
   assign resp_dbz   = resp_dbz_q && resp_valid;
   assign resp_ovf   = resp_ovf_q && resp_valid;
   assign resp_err   = resp_err_q && resp_valid;

endmodule
`default_nettype wire
